// File: rtl/periodic_write_checker.sv
// periodic_write_checker: watches a writer that must leave a value unwritten
// for INIT_CYC cycles after start and then deliver EXPECT within DEADLINE_CYC
// cycles. Reports pass/fail with a cause code and the match latency.
module periodic_write_checker #(
  parameter int unsigned             WIDTH        = 4,
  parameter logic [WIDTH-1:0]        EXPECT       = 4'h5,
  parameter int unsigned             INIT_CYC     = 1,
  parameter int unsigned             DEADLINE_CYC = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             value_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [15:0]      latency
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT_WAIT,
    S_DEADLINE_WAIT,
    S_DONE
  } state_t;

  // Failure causes reported on fail_code.
  localparam logic [1:0] CODE_NONE     = 2'd0;
  localparam logic [1:0] CODE_EARLY    = 2'd1;
  localparam logic [1:0] CODE_DEADLINE = 2'd2;
  localparam logic [1:0] CODE_WRONG    = 2'd3;

  // Last counter value of each wait window; both waits stop here so cnt
  // can never wrap.
  localparam logic [15:0] INIT_LAST     = 16'(INIT_CYC - 1);
  localparam logic [15:0] DEADLINE_LAST = 16'(DEADLINE_CYC - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        value_match;

  // Full-width, unsigned compare against the expected constant.
  assign value_match = (value == EXPECT);

  // Check sequencer; every output is a flop updated alongside the state.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // takes priority over every other update, including a pending start.
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= CODE_NONE;
      latency   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop reading the
      // pre-edge values, so ordering inside this block does not matter.
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_INIT_WAIT;
            cnt       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= CODE_NONE;
            latency   <= '0;
          end
        end

        S_INIT_WAIT: begin
          if (cnt == INIT_LAST) begin
            if (value_valid) begin
              // Writer delivered something before it was allowed to.
              state     <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              fail      <= 1'b1;
              fail_code <= CODE_EARLY;
            end else begin
              state <= S_DEADLINE_WAIT;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_DEADLINE_WAIT: begin
          // A match wins even in the final window cycle.
          if (value_valid && value_match) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b1;
            latency <= cnt;
          end else if (value_valid) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_code <= CODE_WRONG;
          end else if (cnt == DEADLINE_LAST) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_code <= CODE_DEADLINE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/periodic_write_checker.md
PERIODIC_WRITE_CHECKER -- requirements
Module: periodic_write_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the width of the monitored value bus.
REQ-002 The block SHALL have parameter EXPECT, default 4'h5, the constant the monitored writer must deliver.
REQ-003 The block SHALL have parameter INIT_CYC, default 1, legal range 1..65535: cycles after start at which the value must still be unwritten.
REQ-004 The block SHALL have parameter DEADLINE_CYC, default 15, legal range 1..65535: cycles allowed for EXPECT to appear after the init check.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  rising-edge clock, sole clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 start  input  1  single-cycle request to begin a check, honoured only in IDLE or DONE.
REQ-009 value  input  WIDTH  value driven by the writer under check.
REQ-010 value_valid  input  1  high when value has been written (replaces the 4-state "unwritten" condition).
REQ-011 busy  output  1  high in INIT_WAIT and DEADLINE_WAIT.
REQ-012 done  output  1  high in DONE.
REQ-013 pass  output  1  check succeeded; valid while done.
REQ-014 fail  output  1  check failed; valid while done; never high together with pass.
REQ-015 fail_code  output  2  0 none, 1 written too early, 2 deadline missed, 3 wrong value.
REQ-016 latency  output  16  cycle index in DEADLINE_WAIT at which EXPECT matched.

Function
REQ-017 The block SHALL implement states IDLE, INIT_WAIT, DEADLINE_WAIT, DONE, with a 16-bit cycle counter cnt.
REQ-018 IDLE or DONE with start=1 SHALL, next cycle, enter INIT_WAIT with cnt=0 and clear pass, fail, fail_code, latency.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 INIT_WAIT SHALL increment cnt each cycle; in the cycle cnt==INIT_CYC-1 it SHALL sample value_valid.
REQ-021 At that sample, value_valid=1 SHALL go to DONE with fail=1, fail_code=1; value_valid=0 SHALL go to DEADLINE_WAIT with cnt=0.
REQ-022 In DEADLINE_WAIT, per cycle, in priority order: value_valid=1 and value==EXPECT -> DONE, pass=1, latency=cnt; value_valid=1 and value!=EXPECT -> DONE, fail=1, fail_code=3; cnt==DEADLINE_CYC-1 -> DONE, fail=1, fail_code=2; else cnt+1.
REQ-023 A match in the cycle cnt==DEADLINE_CYC-1 SHALL report pass, not a deadline miss.
REQ-024 The value comparison SHALL use all WIDTH bits with no sign extension.
REQ-025 pass, fail, fail_code, latency and done SHALL be registered and SHALL hold stable in DONE until start or reset.
REQ-026 The value bus SHALL be ignored outside the sample points of REQ-020 and REQ-022.
REQ-027 cnt SHALL never wrap, because both waits terminate at their parameter limit.

Reset
REQ-028 reset=1 at a rising edge SHALL force IDLE, cnt=0, busy=0, done=0, pass=0, fail=0, fail_code=0, latency=0, overriding start.
REQ-029 Reset asserted mid-check SHALL abort the check with no pass or fail reported; a later start SHALL begin a fresh check.

Verification
All scenarios use WIDTH=4, EXPECT=5, INIT_CYC=1, DEADLINE_CYC=15.
REQ-030 Start at cycle 0; value_valid rises with value=5 at cycle 11 -> done at cycle 12, pass=1, fail_code=0, latency=9.
REQ-031 Start; value_valid=1 at the init sample (cycle 1) -> done at cycle 2, fail=1, fail_code=1.
REQ-032 Start; value_valid stays 0 -> done at cycle 17, fail=1, fail_code=2.
REQ-033 Start; value_valid=1 with value=4'hA at cycle 5 -> done at cycle 6, fail=1, fail_code=3.
REQ-034 Start; match exactly at cnt=14 (cycle 16) -> pass=1, latency=14.
REQ-035 Start, reset at cycle 6, then start again at cycle 8 -> outputs zero through cycle 8, new check timed from cycle 8; a start pulse while busy is ignored.
